// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI command transmitter and response receiver.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_HDR  = 3'd2,
    ST_CRC  = 3'd3,
    ST_STOP = 3'd4,
    ST_DONE = 3'd5
  } sd_state_e;

  localparam int         SD_FRAME_BITS = 48;
  localparam int         SD_HDR_BITS   = 40;
  localparam logic [6:0] SD_CRC7_POLY  = 7'h09;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD17  = 6'd17;

  // One serial CRC7 step: feedback is the outgoing MSB xor the new data bit.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 accumulator; clear wins over enable.
module crc7_serial
  import sd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  // Next CRC value: zero on frame start, one step per header bit.
  always_comb begin
    crc_d = crc_q;
    if (clear)       crc_d = 7'h00;
    else if (enable) crc_d = crc7_step(crc_q, bit_in);
  end

  // CRC register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) crc_q <= 7'h00;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/send_sd_command.sv
// Serialises one 48-bit SD SPI command frame (lead-in ones, header, CRC7, stop) MSB first.
module send_sd_command
  import sd_pkg::*;
#(
  parameter int LEAD_ONES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmdIndex,
  input  logic [31:0] argument,
  output logic        SDout,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] HDR_LAST   = 6'(SD_HDR_BITS - 1);
  localparam logic [5:0] CRC_LAST   = 6'd6;
  localparam bit         HAS_LEAD   = (LEAD_ONES > 0);
  localparam logic [5:0] ACCEPT_CNT = HAS_LEAD ? 6'(LEAD_ONES - 1) : HDR_LAST;

  sd_state_e   state_q, state_d;
  logic [39:0] shift_q, shift_d;
  logic [5:0]  count_q, count_d;
  logic [6:0]  crc_sr_q, crc_sr_d;   // copy of the finished CRC, shifted out in ST_CRC
  logic        crc_clr, crc_en;
  logic [6:0]  crc_val;

  crc7_serial u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clr),
    .enable (crc_en),
    .bit_in (shift_q[39]),
    .crc    (crc_val)
  );

  // Next-state, datapath and counter control.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    crc_sr_d = crc_sr_q;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = {2'b01, cmdIndex, argument};
          crc_clr = 1'b1;
          count_d = ACCEPT_CNT;
          state_d = HAS_LEAD ? ST_LEAD : ST_HDR;
        end
      end
      ST_LEAD: begin
        if (count_q == 6'd0) begin
          state_d = ST_HDR;
          count_d = HDR_LAST;
        end else begin
          count_d = count_q - 6'd1;
        end
      end
      ST_HDR: begin
        crc_en  = 1'b1;
        shift_d = {shift_q[38:0], 1'b0};
        if (count_q == 6'd0) begin
          // The accumulator only holds the final CRC after this edge, so
          // fold the last header bit in here for the shift-out copy.
          state_d  = ST_CRC;
          count_d  = CRC_LAST;
          crc_sr_d = crc7_step(crc_val, shift_q[39]);
        end else begin
          count_d = count_q - 6'd1;
        end
      end
      ST_CRC: begin
        crc_sr_d = {crc_sr_q[5:0], 1'b0};
        if (count_q == 6'd0) state_d = ST_STOP;
        else                 count_d = count_q - 6'd1;
      end
      ST_STOP: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, shift register, counter and CRC copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= 40'h0;
      count_q  <= 6'd0;
      crc_sr_q <= 7'h00;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      crc_sr_q <= crc_sr_d;
    end
  end

  // Outputs decoded purely from registered state; the line idles high.
  always_comb begin
    SDout = 1'b1;
    case (state_q)
      ST_HDR:  SDout = shift_q[39];
      ST_CRC:  SDout = crc_sr_q[6];
      default: SDout = 1'b1;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_send_sd_command.sv
// Directed bench for send_sd_command with LEAD_ONES=8 and LEAD_ONES=0 instances.
module tb_send_sd_command;
  import sd_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start8, start0;
  logic [5:0]  cmdIndex;
  logic [31:0] argument;
  logic        sd8, busy8, done8;
  logic        sd0, busy0, done0;

  int tests = 0;
  int fails = 0;

  logic sd_log   [0:255];
  logic busy_log [0:255];
  logic done_log [0:255];
  logic rst_sd, rst_busy, rst_done;

  localparam logic [47:0] F_CMD0  = 48'h40_00000000_95;
  localparam logic [47:0] F_CMD8  = 48'h48_000001AA_87;
  localparam logic [47:0] F_CMD55 = 48'h77_00000000_65;

  always #5 clock = ~clock;

  send_sd_command #(.LEAD_ONES(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .cmdIndex(cmdIndex),
    .argument(argument), .SDout(sd8), .busy(busy8), .done(done8)
  );

  send_sd_command #(.LEAD_ONES(0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .cmdIndex(cmdIndex),
    .argument(argument), .SDout(sd0), .busy(busy0), .done(done0)
  );

  // Raise start at a falling edge; the next rising edge is E0.
  task automatic begin_frame(input bit use0, input logic [5:0] idx, input logic [31:0] arg);
    @(negedge clock);
    cmdIndex = idx;
    argument = arg;
    if (use0) start0 = 1'b1; else start8 = 1'b1;
  endtask

  // Log outputs at the falling edge after E0+k, k = 0..n-1, with optional events.
  task automatic capture(input bit use0, input int n, input int drop_k,
                         input int poke_k, input int rst_k);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      sd_log[k]   = use0 ? sd0   : sd8;
      busy_log[k] = use0 ? busy0 : busy8;
      done_log[k] = use0 ? done0 : done8;
      if (k == drop_k) begin start8 = 1'b0; start0 = 1'b0; end
      if (poke_k >= 0 && k == poke_k) begin
        cmdIndex = CMD17;
        argument = 32'hDEADBEEF;
        if (use0) start0 = 1'b1; else start8 = 1'b1;
      end
      if (poke_k >= 0 && k == poke_k + 1) begin start8 = 1'b0; start0 = 1'b0; end
      if (rst_k >= 0 && k == rst_k) begin
        reset = 1'b1;
        #1;
        rst_sd   = use0 ? sd0   : sd8;
        rst_busy = use0 ? busy0 : busy8;
        rst_done = use0 ? done0 : done8;
      end
      if (rst_k >= 0 && k == rst_k + 2) reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    tests++; if (sd8 !== 1'b1)   begin fails++; $display("FAIL reset_sd8: got %b want 1", sd8); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL reset_done8: got %b want 0", done8); end
    tests++; if (sd0 !== 1'b1)   begin fails++; $display("FAIL reset_sd0: got %b want 1", sd0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy0: got %b want 0", busy0); end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    tests++; if (sd8 !== 1'b1 || busy8 !== 1'b0)
      begin fails++; $display("FAIL idle_after_reset: sd=%b busy=%b want sd=1 busy=0", sd8, busy8); end
  endtask

  task automatic test_single_frame(input string name, input logic [5:0] idx,
                                   input logic [31:0] arg, input logic [47:0] exp);
    logic [47:0] got;
    int lead_bad, ndone, nbusy, tail_bad;
    begin_frame(1'b0, idx, arg);
    capture(1'b0, 70, 0, -1, -1);
    lead_bad = 0; ndone = 0; nbusy = 0; tail_bad = 0;
    for (int i = 0; i < 8; i++) if (sd_log[i] !== 1'b1) lead_bad++;
    for (int i = 0; i < 48; i++) got[47-i] = sd_log[8+i];
    for (int i = 0; i < 70; i++) begin
      if (done_log[i] === 1'b1) ndone++;
      if (busy_log[i] === 1'b1) nbusy++;
    end
    for (int i = 56; i < 70; i++) if (sd_log[i] !== 1'b1) tail_bad++;
    tests++; if (busy_log[0] !== 1'b1) begin fails++; $display("FAIL %s busy_rise: got %b want 1", name, busy_log[0]); end
    tests++; if (lead_bad != 0) begin fails++; $display("FAIL %s lead_ones: %0d bad bits want 0", name, lead_bad); end
    tests++; if (got !== exp) begin fails++; $display("FAIL %s frame: got %h want %h", name, got, exp); end
    tests++; if (done_log[56] !== 1'b1 || ndone != 1)
      begin fails++; $display("FAIL %s done: at56=%b count=%0d want 1/1", name, done_log[56], ndone); end
    tests++; if (nbusy != 57) begin fails++; $display("FAIL %s busy_len: got %0d want 57", name, nbusy); end
    tests++; if (tail_bad != 0) begin fails++; $display("FAIL %s idle_high: %0d low bits want 0", name, tail_bad); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] f1, f2;
    int ndone;
    begin_frame(1'b0, CMD55, 32'h0);
    capture(1'b0, 130, 58, -1, -1);
    for (int i = 0; i < 48; i++) begin
      f1[47-i] = sd_log[8+i];
      f2[47-i] = sd_log[66+i];
    end
    ndone = 0;
    for (int i = 0; i < 130; i++) if (done_log[i] === 1'b1) ndone++;
    tests++; if (f1 !== F_CMD55) begin fails++; $display("FAIL b2b frame1: got %h want %h", f1, F_CMD55); end
    tests++; if (done_log[56] !== 1'b1) begin fails++; $display("FAIL b2b done1: got %b want 1", done_log[56]); end
    tests++; if (busy_log[57] !== 1'b0 || sd_log[57] !== 1'b1)
      begin fails++; $display("FAIL b2b idle_gap: busy=%b sd=%b want 0/1", busy_log[57], sd_log[57]); end
    tests++; if (busy_log[58] !== 1'b1) begin fails++; $display("FAIL b2b reaccept: got %b want 1", busy_log[58]); end
    tests++; if (f2 !== F_CMD55) begin fails++; $display("FAIL b2b frame2: got %h want %h", f2, F_CMD55); end
    tests++; if (done_log[114] !== 1'b1 || ndone != 2)
      begin fails++; $display("FAIL b2b done2: at114=%b count=%0d want 1/2", done_log[114], ndone); end
  endtask

  task automatic test_ignore_start();
    logic [47:0] got;
    int ndone, nbusy;
    begin_frame(1'b0, CMD8, 32'h000001AA);
    capture(1'b0, 80, 0, 20, -1);
    for (int i = 0; i < 48; i++) got[47-i] = sd_log[8+i];
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 80; i++) begin
      if (done_log[i] === 1'b1) ndone++;
      if (busy_log[i] === 1'b1) nbusy++;
    end
    tests++; if (got !== F_CMD8) begin fails++; $display("FAIL ignore frame: got %h want %h", got, F_CMD8); end
    tests++; if (ndone != 1) begin fails++; $display("FAIL ignore done_count: got %0d want 1", ndone); end
    tests++; if (nbusy != 57) begin fails++; $display("FAIL ignore busy_len: got %0d want 57", nbusy); end
  endtask

  task automatic test_reset_mid();
    logic [47:0] got;
    int ndone;
    begin_frame(1'b0, CMD8, 32'h000001AA);
    capture(1'b0, 70, 0, -1, 28);   // k=28 is header bit 20
    ndone = 0;
    for (int i = 0; i < 70; i++) if (done_log[i] === 1'b1) ndone++;
    tests++; if (rst_sd !== 1'b1) begin fails++; $display("FAIL midreset sd: got %b want 1", rst_sd); end
    tests++; if (rst_busy !== 1'b0) begin fails++; $display("FAIL midreset busy: got %b want 0", rst_busy); end
    tests++; if (rst_done !== 1'b0) begin fails++; $display("FAIL midreset done: got %b want 0", rst_done); end
    tests++; if (ndone != 0) begin fails++; $display("FAIL midreset no_done: got %0d want 0", ndone); end
    begin_frame(1'b0, CMD0, 32'h0);
    capture(1'b0, 60, 0, -1, -1);
    for (int i = 0; i < 48; i++) got[47-i] = sd_log[8+i];
    tests++; if (got !== F_CMD0) begin fails++; $display("FAIL midreset refire: got %h want %h", got, F_CMD0); end
  endtask

  task automatic test_lead_zero();
    logic [47:0] got;
    int ndone, nbusy;
    begin_frame(1'b1, CMD0, 32'h0);
    capture(1'b1, 60, 0, -1, -1);
    for (int i = 0; i < 48; i++) got[47-i] = sd_log[i];
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_log[i] === 1'b1) ndone++;
      if (busy_log[i] === 1'b1) nbusy++;
    end
    tests++; if (sd_log[0] !== 1'b0) begin fails++; $display("FAIL lead0 start_bit: got %b want 0", sd_log[0]); end
    tests++; if (got !== F_CMD0) begin fails++; $display("FAIL lead0 frame: got %h want %h", got, F_CMD0); end
    tests++; if (done_log[48] !== 1'b1 || ndone != 1)
      begin fails++; $display("FAIL lead0 done: at48=%b count=%0d want 1/1", done_log[48], ndone); end
    tests++; if (nbusy != 49) begin fails++; $display("FAIL lead0 busy_len: got %0d want 49", nbusy); end
  endtask

  initial begin
    reset = 1'b1; start8 = 1'b0; start0 = 1'b0;
    cmdIndex = 6'd0; argument = 32'h0;
    test_reset();
    test_single_frame("cmd0", CMD0, 32'h0, F_CMD0);
    test_single_frame("cmd8", CMD8, 32'h000001AA, F_CMD8);
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_lead_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/send_sd_command.md
# send_sd_command

Serialises one 48-bit SD-card SPI command frame onto the MOSI pin, one bit per clock, MSB first, with the CRC7 generated on the fly. It sits directly upstream of the SD response receiver. The controller pulses `start` with a command index and argument, waits for `done`, and then enables the receiver to capture the R1 response from MISO. Every frame is preceded by a programmable run of idle '1' clocks, as the card requires.

## Interface
- `LEAD_ONES`, default 8: number of '1' bits driven before the frame. Legal range 0..63.
- `clock`  input  1  single system clock. One bit is shifted per rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to send a frame. Sampled only in IDLE.
- `cmdIndex`  input  6  command number, e.g. 0 for CMD0. Sampled with `start`.
- `argument`  input  32  command argument. Sampled with `start`.
- `SDout`  output  1  MOSI data. Idles high.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse after the stop bit.

## Operation
- Frame layout, in transmission order:
  - '0'
  - '1'
  - `cmdIndex[5:0]`
  - `argument[31:0]`
  - `crc[6:0]`
  - '1' (stop bit)
- CRC7:
  - Polynomial x^7+x^3+1 (0x09). The register is cleared at frame start.
  - It covers the first 40 frame bits.
  - Per header bit: fb = crc[6] ^ bit; crc <= {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
- State machine:
  - IDLE → LEAD if `start` and LEAD_ONES>0. → HDR if `start` and LEAD_ONES==0. Otherwise stay.
  - LEAD: SDout=1. Lasts LEAD_ONES cycles, then → HDR.
  - HDR: SDout=shift[39]. Shift left one bit and update the CRC each cycle. Lasts 40 cycles, then → CRC.
  - CRC: SDout=crc[6]. Shift the CRC left (no update) each cycle. Lasts 7 cycles, then → STOP.
  - STOP: SDout=1. Lasts 1 cycle, then → DONE.
  - DONE: SDout=1, done=1. Lasts 1 cycle, then → IDLE.
- On the accepting edge (IDLE and `start`):
  - shift <= {2'b01, cmdIndex, argument}
  - crc <= 0
  - count <= LEAD_ONES-1, or 39 if LEAD_ONES==0.
- Down-counter: 6 bits. Reloaded on every state entry: 39 for HDR, 6 for CRC. A state exits when count==0.
- `start` while busy is ignored and not queued. `cmdIndex` and `argument` may change freely after acceptance.
- `SDout`, `busy` and `done` are decoded from the state register plus the shift/CRC MSBs. They carry no combinational path from inputs.

## Timing
- Reset values: state=IDLE, SDout=1, busy=0, done=0, shift=0, crc=0, count=0.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronous). The partial frame is abandoned and no `done` is produced.
- Edge numbering: E0 is the edge that samples `start`=1. Let L=LEAD_ONES.
  - `busy` rises after E0.
  - First frame bit ('0') is on SDout in the cycle after edge E0+L.
  - Stop bit is in the cycle after edge E0+L+47.
  - `done` is high in the cycle after edge E0+L+48.
  - `busy` falls after edge E0+L+49.
- Total occupancy: L+49 cycles.
- Back-to-back frames: `start` held high continuously produces the next acceptance on the first edge in IDLE. This leaves exactly one IDLE cycle (SDout=1) between `done` and the next lead-in.
- Downstream handshake: the controller may enable the receiver in the same cycle `done` is high. SDout stays 1 from that point on.

## Structure
Shared package `sd_pkg` holds:
- State encodings.
- `SD_FRAME_BITS` = 48.
- `SD_HDR_BITS` = 40.
- `SD_CRC7_POLY` = 7'h09.
- Command index constants: CMD0, CMD8, CMD55, ACMD41, CMD17.

The receiver shares this package.

One sub-module is natural: `crc7_serial`.
- Ports: clock, reset, clear, enable, bit in, crc[6:0] out.
- The CRC-state shift-out is done in the parent by a separate shift of a copy loaded at HDR→CRC.

## Test plan
- CMD0, argument 0x00000000, LEAD_ONES=8 → 8 ones, then bytes 40 00 00 00 00 95 on SDout. `done` one cycle at E0+57 offset. `busy` high for exactly 57 cycles.
- CMD8, argument 0x000001AA → bytes 48 00 00 01 AA 87 (CRC7 = 0x43).
- CMD55, argument 0 → bytes 77 00 00 00 00 65 (CRC7 = 0x32). Then `start` held high across `done` → second frame begins after exactly one IDLE cycle.
- `start` pulsed with a different index during HDR → ignored; the frame in flight is unchanged and only one `done` is seen.
- Reset asserted at header bit 20 → SDout=1, busy=0 immediately. No `done`. A subsequent CMD0 produces a correct 40 00 00 00 00 95 frame.
- LEAD_ONES=0, CMD0 → '0' start bit on SDout in the cycle after E0. `done` after 49 cycles.
